user_au_filter_sched: RTL and testbench

USER_AU_FILTER_SCHED -- requirements
Module: user_au_filter_sched

---
 rtl/user_au_filter_pkg.sv | 20 ++
 rtl/user_au_filter_sched_if.sv | 23 ++
 rtl/user_au_rr_arb.sv | 27 ++
 rtl/user_au_filter_sched.sv | 113 +++++++++++
 tb/tb_user_au_filter_sched.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/user_au_filter_pkg.sv
// Shared types and constants for the multi-channel one-pole audio filter scheduler.
package user_au_filter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL_A = 2'd1,
        MUL_B = 2'd2,
        OUT   = 2'd3
    } state_e;

    localparam logic [15:0] Q16 = 16'hFFFF;

    // Headroom over the sample width: 17-bit unsigned coefficient plus a carry bit.
    localparam int AccGuard = 18;

    function automatic int acc_width(input int sample_width);
        return sample_width + AccGuard;
    endfunction

endpackage

// File: rtl/user_au_filter_sched_if.sv
// Sample stream bundle: per-channel input handshake and a single tagged output stream.
interface user_au_filter_sched_if #(
    parameter int NumCh       = 4,
    parameter int SampleWidth = 16
);
    logic [NumCh-1:0]                  in_valid_i;
    logic [NumCh-1:0][SampleWidth-1:0] in_sample_i;
    logic [NumCh-1:0]                  in_ready_o;
    logic                              out_valid_o;
    logic [$clog2(NumCh)-1:0]          out_ch_o;
    logic [SampleWidth-1:0]            out_sample_o;
    logic                              out_ready_i;

    modport master (
        output in_valid_i, in_sample_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_ch_o, out_sample_o
    );

    modport slave (
        input  in_valid_i, in_sample_i, out_ready_i,
        output in_ready_o, out_valid_o, out_ch_o, out_sample_o
    );
endinterface

// File: rtl/user_au_rr_arb.sv
// Round-robin arbiter: first requester strictly after ptr, wrapping, wins.
module user_au_rr_arb #(
    parameter int NumCh = 4
) (
    input  logic [NumCh-1:0]         req,
    input  logic [$clog2(NumCh)-1:0] ptr,
    output logic [NumCh-1:0]         gnt,
    output logic [$clog2(NumCh)-1:0] idx,
    output logic                     any
);
    int c;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        c   = 0;
        for (int i = 1; i <= NumCh; i++) begin
            c = (int'(ptr) + i) % NumCh;
            if (!any && req[c]) begin
                any    = 1'b1;
                gnt[c] = 1'b1;
                idx    = c[$clog2(NumCh)-1:0];
            end
        end
    end
endmodule

// File: rtl/user_au_filter_sched.sv
// Time-shared one-pole filter y = (d*y + (65535-d)*x) >> 16 over NumCh channels, one multiplier.
//   state | meaning
//   IDLE  | waiting; grants one requesting channel round-robin
//   MUL_A | acc = d * y[ch]
//   MUL_B | acc += (65535-d) * x, y[ch] updated
//   OUT   | result presented until out_ready_i
module user_au_filter_sched
    import user_au_filter_pkg::*;
#(
    parameter int NumCh       = 4,
    parameter int SampleWidth = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [15:0]                   decay_i,
    input  logic                          clear_i,
    user_au_filter_sched_if.slave         bus,
    output logic                          busy_o,
    output logic [31:0]                   sample_cnt_o
);
    localparam int ChW  = $clog2(NumCh);
    localparam int AccW = acc_width(SampleWidth);

    state_e state_q, state_d;

    logic [ChW-1:0]                ptr_q, ch_q, gnt_idx;
    logic [NumCh-1:0]              gnt;
    logic                          gnt_any, take, handshake;
    logic [15:0]                   d_q, dc_q;
    logic signed [SampleWidth-1:0] x_q, y_out_q, y_new;
    logic signed [SampleWidth-1:0] y_q [NumCh];
    logic signed [AccW-1:0]        acc_q, coef_ext, data_ext, product, sum;

    user_au_rr_arb #(.NumCh(NumCh)) u_arb (
        .req (bus.in_valid_i),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    assign take      = (state_q == IDLE) && !clear_i && !rst_i && gnt_any;
    assign handshake = bus.out_valid_o && bus.out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (take) state_d = MUL_A;
                MUL_A:   state_d = MUL_B;
                MUL_B:   state_d = OUT;
                OUT:     if (bus.out_ready_i) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.in_ready_o  = take ? gnt : '0;
        bus.out_valid_o = (state_q == OUT) && !clear_i;
        busy_o          = (state_q != IDLE);
    end

    assign bus.out_ch_o     = ch_q;
    assign bus.out_sample_o = y_out_q;

    // Single multiplier: coefficient is zero-extended to keep it non-negative.
    always_comb begin
        coef_ext       = '0;
        coef_ext[15:0] = (state_q == MUL_A) ? d_q : dc_q;
        data_ext       = (state_q == MUL_A) ? y_q[ch_q] : x_q;
        product        = coef_ext * data_ext;
        sum            = acc_q + product;
        y_new          = SampleWidth'(sum >>> 16);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q        <= ChW'(NumCh - 1);
            ch_q         <= '0;
            d_q          <= '0;
            dc_q         <= '0;
            x_q          <= '0;
            acc_q        <= '0;
            y_out_q      <= '0;
            sample_cnt_o <= '0;
            for (int i = 0; i < NumCh; i++) y_q[i] <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < NumCh; i++) y_q[i] <= '0;
        end else begin
            if (take) begin
                ptr_q <= gnt_idx;
                ch_q  <= gnt_idx;
                d_q   <= decay_i;
                dc_q  <= Q16 - decay_i;
                x_q   <= $signed(bus.in_sample_i[gnt_idx]);
            end
            if (state_q == MUL_A) acc_q <= product;
            if (state_q == MUL_B) begin
                y_q[ch_q] <= y_new;
                y_out_q   <= y_new;
            end
            if (handshake) sample_cnt_o <= sample_cnt_o + 32'd1;
        end
    end
endmodule

// File: tb/tb_user_au_filter_sched.sv
// Directed bench for user_au_filter_sched: vector table plus hand-written multi-cycle sequences.
module tb_user_au_filter_sched;
    logic        clk;
    logic        rst;
    logic [15:0] decay;
    logic        clear;
    logic        busy;
    logic [31:0] sample_cnt;
    int          errors = 0;
    int          checks = 0;

    user_au_filter_sched_if #(.NumCh(4), .SampleWidth(16)) bus ();

    user_au_filter_sched #(.NumCh(4), .SampleWidth(16)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .decay_i      (decay),
        .clear_i      (clear),
        .bus          (bus),
        .busy_o       (busy),
        .sample_cnt_o (sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        logic [15:0] d;
        int          x;
        int          exp_y;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Starts and ends on a falling edge; result must appear exactly 3 cycles after the grant.
    task automatic run_vec(input int ch, input logic [15:0] d, input int x, input int exp_y);
        bus.in_valid_i         = '0;
        bus.in_valid_i[ch]     = 1'b1;
        bus.in_sample_i[ch]    = 16'(x);
        decay                  = d;
        bus.out_ready_i        = 1'b1;
        #1;
        chk("vec_grant", {28'h0, bus.in_ready_o}, 32'(1 << ch));
        @(negedge clk);
        bus.in_valid_i = '0;
        decay          = ~d;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("vec_valid", {31'h0, bus.out_valid_o}, 32'd1);
        chk("vec_ch", {30'h0, bus.out_ch_o}, 32'(ch));
        chk("vec_y", {16'h0, bus.out_sample_o}, {16'h0, 16'(exp_y)});
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst             = 1'b1;
        clear           = 1'b0;
        decay           = '0;
        bus.in_valid_i  = '0;
        bus.in_sample_i = '0;
        bus.out_ready_i = 1'b1;

        vecs[0] = '{0, 16'h0000,  16384,  16383};
        vecs[1] = '{0, 16'h0000, -16384, -16384};
        vecs[2] = '{1, 16'h8000,  16384,   8191};
        vecs[3] = '{1, 16'h8000,  16384,  12287};
        vecs[4] = '{0, 16'hFFFF,   1000, -16384};
        vecs[5] = '{3, 16'h4000,  -1000,   -750};
        vecs[6] = '{2, 16'h0000,  32767,  32766};
        vecs[7] = '{2, 16'h0000, -32768, -32768};

        repeat (3) @(negedge clk);
        bus.in_valid_i = 4'b1111;
        #1;
        chk("rst_valid", {31'h0, bus.out_valid_o}, 32'd0);
        chk("rst_ready", {28'h0, bus.in_ready_o}, 32'd0);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_cnt", sample_cnt, 32'd0);
        chk("rst_ch", {30'h0, bus.out_ch_o}, 32'd0);
        chk("rst_y", {16'h0, bus.out_sample_o}, 32'd0);
        bus.in_valid_i = '0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i].ch, vecs[i].d, vecs[i].x, vecs[i].exp_y);
        #1;
        chk("table_cnt", sample_cnt, 32'd8);

        // Round-robin with all channels requesting, starting from a fresh pointer.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst             = 1'b0;
        bus.in_valid_i  = 4'b1111;
        bus.in_sample_i = '0;
        decay           = '0;
        bus.out_ready_i = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            if (k == 17) bus.in_valid_i = '0;
            #1;
            if (k <= 16) begin
                if (k % 4 == 0) chk("rr_grant", {28'h0, bus.in_ready_o}, 32'(1 << ((k / 4) % 4)));
                else            chk("rr_idle_gap", {28'h0, bus.in_ready_o}, 32'd0);
            end
            if (k == 20) chk("rr_cnt", sample_cnt, 32'd5);
            @(negedge clk);
        end

        // Output stall: data held, no grants while waiting.
        bus.in_valid_i     = 4'b0001;
        bus.in_sample_i[0] = 16'd100;
        decay              = '0;
        bus.out_ready_i    = 1'b0;
        #1;
        chk("stall_grant", {28'h0, bus.in_ready_o}, 32'd1);
        @(negedge clk);
        bus.in_valid_i = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("stall_valid", {31'h0, bus.out_valid_o}, 32'd1);
            chk("stall_y", {16'h0, bus.out_sample_o}, 32'd99);
            chk("stall_ready", {28'h0, bus.in_ready_o}, 32'd0);
            chk("stall_busy", {31'h0, busy}, 32'd1);
            @(negedge clk);
        end
        chk("stall_ch", {30'h0, bus.out_ch_o}, 32'd0);
        bus.in_valid_i  = '0;
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        #1;
        chk("stall_release_cnt", sample_cnt, 32'd6);
        chk("stall_release_valid", {31'h0, bus.out_valid_o}, 32'd0);

        // Clear in IDLE blocks the grant.
        @(negedge clk);
        clear          = 1'b1;
        bus.in_valid_i = 4'b0010;
        #1;
        chk("clr_idle_ready", {28'h0, bus.in_ready_o}, 32'd0);
        @(negedge clk);
        clear          = 1'b0;
        bus.in_valid_i = '0;
        #1;
        chk("clr_idle_busy", {31'h0, busy}, 32'd0);

        // Clear during MUL_B of channel 2 aborts it and zeroes every channel state.
        @(negedge clk);
        bus.in_valid_i     = 4'b0100;
        bus.in_sample_i[2] = 16'd5000;
        decay              = '0;
        #1;
        chk("clr_grant", {28'h0, bus.in_ready_o}, 32'd4);
        @(negedge clk);
        bus.in_valid_i = '0;
        @(negedge clk);
        #1;
        chk("clr_busy_mulb", {31'h0, busy}, 32'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("clr_no_out", {31'h0, bus.out_valid_o}, 32'd0);
            chk("clr_idle", {31'h0, busy}, 32'd0);
            @(negedge clk);
        end
        chk("clr_cnt", sample_cnt, 32'd6);
        run_vec(2, 16'h8000, 16384, 8191);
        run_vec(0, 16'h8000, 16384, 8191);

        // Reset while holding a result in OUT.
        bus.in_valid_i     = 4'b1000;
        bus.in_sample_i[3] = 16'd1234;
        decay              = '0;
        bus.out_ready_i    = 1'b0;
        #1;
        chk("rout_grant", {28'h0, bus.in_ready_o}, 32'd8);
        @(negedge clk);
        bus.in_valid_i = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rout_in_out", {31'h0, bus.out_valid_o}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rout_valid", {31'h0, bus.out_valid_o}, 32'd0);
        chk("rout_cnt", sample_cnt, 32'd0);
        chk("rout_busy", {31'h0, busy}, 32'd0);
        chk("rout_y", {16'h0, bus.out_sample_o}, 32'd0);
        rst             = 1'b0;
        bus.in_valid_i  = 4'b1111;
        bus.out_ready_i = 1'b1;
        #1;
        chk("rout_next_grant", {28'h0, bus.in_ready_o}, 32'd1);
        @(negedge clk);
        bus.in_valid_i = '0;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
